// File: rtl/dut_io_stream_ctrl.sv
// Word-serial bridge between a 32-bit AXI-style stream and wide DUT vectors.
// Input path: assembles 32-bit words into dut_input_vec, pulsing dut_input_valid on completion.
// Output path: snapshots dut_output_vec on capture and streams it out word by word.
module dut_io_stream_ctrl #(
    parameter int unsigned dut_input_width  = 256,
    parameter int unsigned dut_output_width = 256,
    localparam int unsigned IW = (dut_input_width + 31) / 32,
    localparam int unsigned OW = (dut_output_width + 31) / 32,
    localparam int unsigned CW = $clog2(IW) + 1,
    localparam int unsigned XW = $clog2(OW) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 in_word,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_hold,
    input  logic                        in_abort,
    output logic [dut_input_width-1:0]  dut_input_vec,
    output logic                        dut_input_valid,
    input  logic [dut_output_width-1:0] dut_output_vec,
    input  logic                        capture,
    output logic [31:0]                 out_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [CW-1:0]               in_count
);

    typedef enum logic {StIdle, StSend} state_e;

    logic [32*IW-1:0] asm_q;
    logic [32*IW-1:0] asm_full;
    logic             hs;
    logic             last_hs;

    state_e           state_q, state_d;
    logic [XW-1:0]    idx_q, idx_d;
    logic [32*OW-1:0] snap_q, snap_d;

    assign in_ready = !in_hold && !reset;
    // Abort takes priority: a word offered alongside abort is dropped.
    assign hs       = in_valid && in_ready && !in_abort;
    assign last_hs  = hs && (in_count == CW'(IW - 1));

    // Assembly buffer with the current word merged in at slot in_count.
    always_comb begin
        asm_full = asm_q;
        for (int k = 0; k < int'(IW); k++) begin
            if (in_count == CW'(k)) begin
                asm_full[32*k +: 32] = in_word;
            end
        end
    end

    // Input assembly state; dut_input_vec only updates on a completed vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_q           <= '0;
            in_count        <= '0;
            dut_input_vec   <= '0;
            dut_input_valid <= 1'b0;
        end else begin
            dut_input_valid <= last_hs;
            if (in_abort) begin
                in_count <= '0;
            end else if (hs) begin
                asm_q <= asm_full;
                if (last_hs) begin
                    in_count      <= '0;
                    dut_input_vec <= asm_full[dut_input_width-1:0];
                end else begin
                    in_count <= in_count + CW'(1);
                end
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Output FSM next-state and stream outputs; capture is ignored while sending.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        out_valid = 1'b0;
        out_word  = '0;
        out_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (capture) begin
                    snap_d                       = '0;
                    snap_d[dut_output_width-1:0] = dut_output_vec;
                    idx_d                        = '0;
                    state_d                      = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                for (int k = 0; k < int'(OW); k++) begin
                    if (idx_q == XW'(k)) begin
                        out_word = snap_q[32*k +: 32];
                    end
                end
                out_last = (idx_q == XW'(OW - 1));
                if (out_ready) begin
                    if (out_last) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + XW'(1);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dut_io_stream_ctrl.sv
// Directed bench for dut_io_stream_ctrl: a default-width instance and a 40-bit instance.
module tb_dut_io_stream_ctrl;

    logic clk = 1'b0;
    logic reset;

    // Default-width instance (256/256)
    logic [31:0]  in_word;
    logic         in_valid, in_hold, in_abort, capture, out_ready;
    logic         in_ready, div_valid, out_valid, out_last;
    logic [255:0] dov, div;
    logic [31:0]  out_word;
    logic [3:0]   in_count;

    // 40-bit instance
    logic [31:0]  n_in_word;
    logic         n_in_valid, n_in_hold, n_in_abort, n_capture, n_out_ready;
    logic         n_in_ready, n_div_valid, n_out_valid, n_out_last;
    logic [39:0]  n_dov, n_div;
    logic [31:0]  n_out_word;
    logic [1:0]   n_in_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dut_io_stream_ctrl u_dut (
        .clk(clk), .reset(reset),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
        .in_hold(in_hold), .in_abort(in_abort),
        .dut_input_vec(div), .dut_input_valid(div_valid),
        .dut_output_vec(dov), .capture(capture),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .in_count(in_count)
    );

    dut_io_stream_ctrl #(.dut_input_width(40), .dut_output_width(40)) u_dut40 (
        .clk(clk), .reset(reset),
        .in_word(n_in_word), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .in_hold(n_in_hold), .in_abort(n_in_abort),
        .dut_input_vec(n_div), .dut_input_valid(n_div_valid),
        .dut_output_vec(n_dov), .capture(n_capture),
        .out_word(n_out_word), .out_valid(n_out_valid), .out_ready(n_out_ready),
        .out_last(n_out_last), .in_count(n_in_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_word = '0; in_valid = 0; in_hold = 0; in_abort = 0; capture = 0; out_ready = 0;
        dov = '0;
        n_in_word = '0; n_in_valid = 0; n_in_hold = 0; n_in_abort = 0; n_capture = 0;
        n_out_ready = 0; n_dov = '0;
        step();
        step();
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (div !== 256'h0) begin errors++;
            $display("FAIL rst_vec: got %h expected 0", div); end
        checks++; if (div_valid !== 1'b0) begin errors++;
            $display("FAIL rst_valid: got %b expected 0", div_valid); end
        checks++; if (in_count !== 4'd0) begin errors++;
            $display("FAIL rst_count: got %0d expected 0", in_count); end
        checks++; if ({out_valid, out_last, out_word} !== 34'h0) begin errors++;
            $display("FAIL rst_out: got v=%b l=%b w=%h expected all 0",
                     out_valid, out_last, out_word); end
        checks++; if (n_div !== 40'h0) begin errors++;
            $display("FAIL rst_vec40: got %h expected 0", n_div); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL in_ready_after_rst: got %b expected 1", in_ready); end
    endtask

    task automatic test_stream8();
        logic [255:0] exp_vec = '0;
        logic [3:0]   exp_cnt;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_word  = 32'(k);
            exp_vec[32*k +: 32] = 32'(k);
            step();
            exp_cnt = 4'((k + 1) % 8);
            checks++; if (in_count !== exp_cnt) begin errors++;
                $display("FAIL s8_count[%0d]: got %0d expected %0d", k, in_count, exp_cnt); end
            checks++; if (div_valid !== (k == 7)) begin errors++;
                $display("FAIL s8_pulse[%0d]: got %b expected %b", k, div_valid, k == 7); end
            checks++; if (div !== ((k == 7) ? exp_vec : 256'h0)) begin errors++;
                $display("FAIL s8_vec[%0d]: got %h", k, div); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (div_valid !== 1'b0) begin errors++;
            $display("FAIL s8_pulse_end: got %b expected 0", div_valid); end
        checks++; if (div !== exp_vec) begin errors++;
            $display("FAIL s8_vec_hold: got %h expected %h", div, exp_vec); end
    endtask

    task automatic test_hold();
        in_hold = 1'b1; in_valid = 1'b1; in_word = 32'd99;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL hold_ready: got %b expected 0", in_ready); end
        step();
        checks++; if (in_count !== 4'd0) begin errors++;
            $display("FAIL hold_count: got %0d expected 0", in_count); end
        in_hold = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_abort();
        logic [255:0] exp_vec = '0;
        int pulses = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_word  = 32'hDEAD_0000 + 32'(k);
            step();
        end
        checks++; if (in_count !== 4'd3) begin errors++;
            $display("FAIL abort_pre_count: got %0d expected 3", in_count); end
        in_abort = 1'b1; in_word = 32'h0000_0BAD;
        step();
        in_abort = 1'b0;
        checks++; if (in_count !== 4'd0) begin errors++;
            $display("FAIL abort_count: got %0d expected 0", in_count); end
        for (int k = 0; k < 8; k++) begin
            in_word = 32'h10 + 32'(k);
            exp_vec[32*k +: 32] = 32'h10 + 32'(k);
            step();
            if (div_valid === 1'b1) pulses++;
        end
        in_valid = 1'b0;
        step();
        if (div_valid === 1'b1) pulses++;
        checks++; if (pulses != 1) begin errors++;
            $display("FAIL abort_pulses: got %0d expected 1", pulses); end
        checks++; if (div !== exp_vec) begin errors++;
            $display("FAIL abort_vec: got %h expected %h", div, exp_vec); end
        checks++; if (in_count !== 4'd0) begin errors++;
            $display("FAIL abort_end_count: got %0d expected 0", in_count); end
    endtask

    task automatic test_width40_in();
        n_in_valid = 1'b1; n_in_word = 32'hAAAA_AAAA;
        step();
        checks++; if (n_in_count !== 2'd1 || n_div_valid !== 1'b0) begin errors++;
            $display("FAIL w40_first: got cnt=%0d v=%b expected cnt=1 v=0",
                     n_in_count, n_div_valid); end
        n_in_word = 32'hFFFF_FF12;
        step();
        n_in_valid = 1'b0;
        checks++; if (n_div !== 40'h12_AAAA_AAAA) begin errors++;
            $display("FAIL w40_vec: got %h expected 12aaaaaaaa", n_div); end
        checks++; if (n_div_valid !== 1'b1 || n_in_count !== 2'd0) begin errors++;
            $display("FAIL w40_done: got v=%b cnt=%0d expected v=1 cnt=0",
                     n_div_valid, n_in_count); end
    endtask

    task automatic test_stream_out();
        int e = 0;
        for (int i = 0; i < 8; i++) dov[32*i +: 32] = 32'(i + 1);
        capture = 1'b1;
        step();
        capture = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++;
            $display("FAIL so_first_valid: got %b expected 1", out_valid); end
        for (int cyc = 0; cyc < 32 && e < 8; cyc++) begin
            out_ready = (cyc % 2 == 0);
            #1;
            checks++; if (out_valid !== 1'b1 || out_word !== 32'(e + 1)) begin errors++;
                $display("FAIL so_word[%0d]: got v=%b w=%h expected v=1 w=%h",
                         cyc, out_valid, out_word, 32'(e + 1)); end
            checks++; if (out_last !== (e == 7)) begin errors++;
                $display("FAIL so_last[%0d]: got %b expected %b", cyc, out_last, e == 7); end
            step();
            if (out_ready) e++;
        end
        out_ready = 1'b0;
        checks++; if (e != 8) begin errors++;
            $display("FAIL so_count: got %0d words expected 8", e); end
        checks++; if (out_valid !== 1'b0 || out_word !== 32'h0) begin errors++;
            $display("FAIL so_idle: got v=%b w=%h expected v=0 w=0", out_valid, out_word); end
    endtask

    task automatic test_width40_out();
        n_dov = 40'hBB_CCCC_CCCC;
        n_capture = 1'b1;
        step();
        n_capture = 1'b0; n_out_ready = 1'b1;
        checks++; if (n_out_valid !== 1'b1 || n_out_word !== 32'hCCCC_CCCC || n_out_last !== 1'b0)
            begin errors++;
            $display("FAIL w40o_w0: got v=%b w=%h l=%b expected v=1 w=cccccccc l=0",
                     n_out_valid, n_out_word, n_out_last); end
        step();
        checks++; if (n_out_word !== 32'h0000_00BB || n_out_last !== 1'b1) begin errors++;
            $display("FAIL w40o_w1: got w=%h l=%b expected w=000000bb l=1",
                     n_out_word, n_out_last); end
        // capture on the final handshake cycle must be ignored
        n_capture = 1'b1; n_dov = 40'h11_2233_4455;
        step();
        n_capture = 1'b0;
        checks++; if (n_out_valid !== 1'b0) begin errors++;
            $display("FAIL w40o_idle: got %b expected 0", n_out_valid); end
        step();
        checks++; if (n_out_valid !== 1'b0) begin errors++;
            $display("FAIL w40o_idle2: got %b expected 0", n_out_valid); end
        n_out_ready = 1'b0;
    endtask

    task automatic test_reset_midsend();
        for (int i = 0; i < 8; i++) dov[32*i +: 32] = 32'h100 + 32'(i);
        capture = 1'b1;
        step();
        capture = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_word = 32'h40 + 32'(c);
            checks++; if (out_word !== 32'h100 + 32'(c)) begin errors++;
                $display("FAIL rm_word[%0d]: got %h expected %h", c, out_word, 32'h100 + 32'(c));
            end
            if (c == 1) begin
                capture = 1'b1;
                for (int i = 0; i < 8; i++) dov[32*i +: 32] = 32'h200 + 32'(i);
            end else begin
                capture = 1'b0;
            end
            step();
        end
        capture = 1'b0;
        checks++; if (out_word !== 32'h103 || in_count !== 4'd3) begin errors++;
            $display("FAIL rm_idx3: got w=%h cnt=%0d expected w=103 cnt=3", out_word, in_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_word !== 32'h0) begin errors++;
            $display("FAIL rm_out_after_rst: got v=%b w=%h expected 0", out_valid, out_word); end
        checks++; if (in_count !== 4'd0 || div !== 256'h0 || div_valid !== 1'b0) begin errors++;
            $display("FAIL rm_in_after_rst: got cnt=%0d v=%b expected cnt=0 v=0 vec=0",
                     in_count, div_valid); end
        step();
        checks++; if (out_valid !== 1'b0 || div_valid !== 1'b0) begin errors++;
            $display("FAIL rm_quiet: got ov=%b iv=%b expected 0", out_valid, div_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream8();
        test_hold();
        test_abort();
        test_width40_in();
        test_stream_out();
        test_width40_out();
        test_reset_midsend();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
